csrng_ctr_drbg_upd_engine: RTL and testbench

CSRNG_CTR_DRBG_UPD_ENGINE -- requirements
Module: csrng_ctr_drbg_upd_engine

---
 rtl/csrng_ctr_drbg_upd_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_csrng_ctr_drbg_upd_engine.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csrng_ctr_drbg_upd_engine.sv
// ---------------------------------------------------------------------------
// csrng_ctr_drbg_upd_engine
//
// CTR_DRBG update function. A command from the command stage carries the
// current key/V and up to SeedLen bits of provided data. The engine runs
// three block encryptions of successively incremented V values, XORs the
// concatenated ciphertext with the provided data and returns the result as
// the new key (upper KeyLen bits) and new V (lower BlkLen bits). The UNI
// command bypasses the encrypter and returns an all-zero key/V.
//
// Optional build macro:
//   CSRNG_UPD_TAG_CHECK_EN - when defined, the command/instance tag that comes
//                            back with each ciphertext is compared against the
//                            tag of the outstanding command; a mismatch moves
//                            the engine into its terminal ERROR state.
// ---------------------------------------------------------------------------
module csrng_ctr_drbg_upd_engine #(
    parameter int Cmd     = 3,
    parameter int StateId = 4,
    parameter int BlkLen  = 128,
    parameter int KeyLen  = 256,
    parameter int SeedLen = 384,
    parameter int CtrLen  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    // command stage -> update request
    input  logic               cmd_upd_req_i,
    output logic               upd_cmd_rdy_o,
    input  logic [Cmd-1:0]     cmd_upd_ccmd_i,
    input  logic [StateId-1:0] cmd_upd_inst_id_i,
    input  logic [SeedLen-1:0] cmd_upd_pdata_i,
    input  logic [KeyLen-1:0]  cmd_upd_key_i,
    input  logic [BlkLen-1:0]  cmd_upd_v_i,
    // update -> block encrypter request
    output logic               upd_benc_req_o,
    input  logic               benc_upd_rdy_i,
    output logic [Cmd-1:0]     upd_benc_ccmd_o,
    output logic [StateId-1:0] upd_benc_inst_id_o,
    output logic [KeyLen-1:0]  upd_benc_key_o,
    output logic [BlkLen-1:0]  upd_benc_v_o,
    // block encrypter -> update ciphertext
    input  logic               benc_upd_ack_i,
    output logic               upd_benc_rdy_o,
    input  logic [Cmd-1:0]     benc_upd_ccmd_i,
    input  logic [StateId-1:0] benc_upd_inst_id_i,
    input  logic [BlkLen-1:0]  benc_upd_v_i,
    // update -> command stage result
    output logic               upd_cmd_ack_o,
    input  logic               cmd_upd_rdy_i,
    output logic [Cmd-1:0]     upd_cmd_ccmd_o,
    output logic [StateId-1:0] upd_cmd_inst_id_o,
    output logic [KeyLen-1:0]  upd_cmd_key_o,
    output logic [BlkLen-1:0]  upd_cmd_v_o,
    // status
    output logic               upd_sm_err_o
);

    localparam logic [Cmd-1:0] CmdUni  = Cmd'(5);
    localparam logic [1:0]     LastBlk = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENC_REQ  = 3'd1,
        ENC_WAIT = 3'd2,
        RESP     = 3'd3,
        ERROR    = 3'd4
    } state_e;

    state_e               state_q;
    logic [Cmd-1:0]       ccmd_q;
    logic [StateId-1:0]   inst_id_q;
    logic [SeedLen-1:0]   pdata_q;
    logic [KeyLen-1:0]    key_q;
    logic [BlkLen-1:0]    v_q;
    logic [BlkLen-1:0]    blk0_q;
    logic [BlkLen-1:0]    blk1_q;
    logic [KeyLen-1:0]    res_key_q;
    logic [BlkLen-1:0]    res_v_q;
    logic [1:0]           blk_cnt_q;
    logic                 benc_req_q;
    logic                 benc_rdy_q;
    logic                 cmd_ack_q;
    logic                 sm_err_q;

    logic [SeedLen-1:0]   upd_temp;
    logic                 tag_err;

    // Counter-mode increment: only the low CtrLen bits count, the upper part
    // of V is carried through untouched and the counter wraps silently.
    function automatic logic [BlkLen-1:0] inc_v(input logic [BlkLen-1:0] v);
        logic [BlkLen-1:0] r;
        r = v;
        r[CtrLen-1:0] = v[CtrLen-1:0] + CtrLen'(1);
        return r;
    endfunction

    // The last ciphertext is folded in straight from the encrypter so the
    // result lands in its register on the same edge that enters RESP.
    assign upd_temp = {blk0_q, blk1_q, benc_upd_v_i} ^ pdata_q;

`ifdef CSRNG_UPD_TAG_CHECK_EN
    // Returned tag must match the single outstanding command.
    assign tag_err = (benc_upd_ccmd_i != ccmd_q) || (benc_upd_inst_id_i != inst_id_q);
`else
    // Tags are passed through the encrypter but not checked in this build.
    logic unused_tag;
    assign unused_tag = ^{benc_upd_ccmd_i, benc_upd_inst_id_i};
    assign tag_err    = 1'b0;
`endif

    // Main control FSM with its datapath registers and registered handshakes.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later statements see
    // half-updated state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the key/V payload registers are reset as well, so no stale
            // key material is ever visible on the outputs after a reset.
            state_q    <= IDLE;
            ccmd_q     <= '0;
            inst_id_q  <= '0;
            pdata_q    <= '0;
            key_q      <= '0;
            v_q        <= '0;
            blk0_q     <= '0;
            blk1_q     <= '0;
            res_key_q  <= '0;
            res_v_q    <= '0;
            blk_cnt_q  <= '0;
            benc_req_q <= 1'b0;
            benc_rdy_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            sm_err_q   <= 1'b0;
        end else if (!enable_i && (state_q inside {IDLE, ENC_REQ, ENC_WAIT, RESP})) begin
            // Disable aborts any operation and scrubs the datapath.
            state_q    <= IDLE;
            ccmd_q     <= '0;
            inst_id_q  <= '0;
            pdata_q    <= '0;
            key_q      <= '0;
            v_q        <= '0;
            blk0_q     <= '0;
            blk1_q     <= '0;
            res_key_q  <= '0;
            res_v_q    <= '0;
            blk_cnt_q  <= '0;
            benc_req_q <= 1'b0;
            benc_rdy_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    benc_req_q <= 1'b0;
                    benc_rdy_q <= 1'b0;
                    cmd_ack_q  <= 1'b0;
                    // upd_cmd_rdy_o is high here since enable_i is high.
                    if (cmd_upd_req_i) begin
                        ccmd_q    <= cmd_upd_ccmd_i;
                        inst_id_q <= cmd_upd_inst_id_i;
                        pdata_q   <= cmd_upd_pdata_i;
                        key_q     <= cmd_upd_key_i;
                        blk_cnt_q <= '0;
                        if (cmd_upd_ccmd_i == CmdUni) begin
                            v_q       <= cmd_upd_v_i;
                            res_key_q <= '0;
                            res_v_q   <= '0;
                            cmd_ack_q <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            // V is pre-incremented so ENC_REQ presents it directly.
                            v_q        <= inc_v(cmd_upd_v_i);
                            benc_req_q <= 1'b1;
                            state_q    <= ENC_REQ;
                        end
                    end
                end

                ENC_REQ: begin
                    if (benc_upd_rdy_i) begin
                        benc_req_q <= 1'b0;
                        benc_rdy_q <= 1'b1;
                        state_q    <= ENC_WAIT;
                    end
                end

                ENC_WAIT: begin
                    if (benc_upd_ack_i) begin
                        benc_rdy_q <= 1'b0;
                        if (tag_err) begin
                            sm_err_q <= 1'b1;
                            state_q  <= ERROR;
                        end else if (blk_cnt_q == LastBlk) begin
                            res_key_q <= upd_temp[SeedLen-1:BlkLen];
                            res_v_q   <= upd_temp[BlkLen-1:0];
                            cmd_ack_q <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            if (blk_cnt_q == 2'd0) begin
                                blk0_q <= benc_upd_v_i;
                            end else begin
                                blk1_q <= benc_upd_v_i;
                            end
                            blk_cnt_q  <= blk_cnt_q + 2'd1;
                            v_q        <= inc_v(v_q);
                            benc_req_q <= 1'b1;
                            state_q    <= ENC_REQ;
                        end
                    end
                end

                RESP: begin
                    if (cmd_upd_rdy_i) begin
                        cmd_ack_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                ERROR: begin
                    benc_req_q <= 1'b0;
                    benc_rdy_q <= 1'b0;
                    cmd_ack_q  <= 1'b0;
                    sm_err_q   <= 1'b1;
                end

                default: begin
                    // Corrupted state encoding: lock up until reset.
                    benc_req_q <= 1'b0;
                    benc_rdy_q <= 1'b0;
                    cmd_ack_q  <= 1'b0;
                    sm_err_q   <= 1'b1;
                    state_q    <= ERROR;
                end
            endcase
        end
    end

    assign upd_cmd_rdy_o      = enable_i && (state_q == IDLE);

    assign upd_benc_req_o     = benc_req_q;
    assign upd_benc_ccmd_o    = ccmd_q;
    assign upd_benc_inst_id_o = inst_id_q;
    assign upd_benc_key_o     = key_q;
    assign upd_benc_v_o       = v_q;
    assign upd_benc_rdy_o     = benc_rdy_q;

    assign upd_cmd_ack_o      = cmd_ack_q;
    assign upd_cmd_ccmd_o     = ccmd_q;
    assign upd_cmd_inst_id_o  = inst_id_q;
    assign upd_cmd_key_o      = res_key_q;
    assign upd_cmd_v_o        = res_v_q;

    assign upd_sm_err_o       = sm_err_q;

endmodule

// File: tb/tb_csrng_ctr_drbg_upd_engine.sv
// ---------------------------------------------------------------------------
// tb_csrng_ctr_drbg_upd_engine
//
// Directed vector table, hand-written corner sequences and randomized
// commands checked against a behavioural model of the CTR_DRBG update.
// A bench-side encrypter answers block requests one cycle after acceptance
// (optionally with random stalls and delays).
// Honours CSRNG_UPD_TAG_CHECK_EN to choose the expected tag-mismatch outcome.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csrng_ctr_drbg_upd_engine;

    localparam logic [2:0]  CMD_INS = 3'd1;
    localparam logic [2:0]  CMD_RES = 3'd2;
    localparam logic [2:0]  CMD_UNI = 3'd5;
    localparam logic [95:0] UP      = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         enable_i;
    logic         cmd_upd_req_i;
    logic         upd_cmd_rdy_o;
    logic [2:0]   cmd_upd_ccmd_i;
    logic [3:0]   cmd_upd_inst_id_i;
    logic [383:0] cmd_upd_pdata_i;
    logic [255:0] cmd_upd_key_i;
    logic [127:0] cmd_upd_v_i;
    logic         upd_benc_req_o;
    logic         benc_upd_rdy_i;
    logic [2:0]   upd_benc_ccmd_o;
    logic [3:0]   upd_benc_inst_id_o;
    logic [255:0] upd_benc_key_o;
    logic [127:0] upd_benc_v_o;
    logic         benc_upd_ack_i;
    logic         upd_benc_rdy_o;
    logic [2:0]   benc_upd_ccmd_i;
    logic [3:0]   benc_upd_inst_id_i;
    logic [127:0] benc_upd_v_i;
    logic         upd_cmd_ack_o;
    logic         cmd_upd_rdy_i;
    logic [2:0]   upd_cmd_ccmd_o;
    logic [3:0]   upd_cmd_inst_id_o;
    logic [255:0] upd_cmd_key_o;
    logic [127:0] upd_cmd_v_o;
    logic         upd_sm_err_o;

    csrng_ctr_drbg_upd_engine dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .cmd_upd_req_i      (cmd_upd_req_i),
        .upd_cmd_rdy_o      (upd_cmd_rdy_o),
        .cmd_upd_ccmd_i     (cmd_upd_ccmd_i),
        .cmd_upd_inst_id_i  (cmd_upd_inst_id_i),
        .cmd_upd_pdata_i    (cmd_upd_pdata_i),
        .cmd_upd_key_i      (cmd_upd_key_i),
        .cmd_upd_v_i        (cmd_upd_v_i),
        .upd_benc_req_o     (upd_benc_req_o),
        .benc_upd_rdy_i     (benc_upd_rdy_i),
        .upd_benc_ccmd_o    (upd_benc_ccmd_o),
        .upd_benc_inst_id_o (upd_benc_inst_id_o),
        .upd_benc_key_o     (upd_benc_key_o),
        .upd_benc_v_o       (upd_benc_v_o),
        .benc_upd_ack_i     (benc_upd_ack_i),
        .upd_benc_rdy_o     (upd_benc_rdy_o),
        .benc_upd_ccmd_i    (benc_upd_ccmd_i),
        .benc_upd_inst_id_i (benc_upd_inst_id_i),
        .benc_upd_v_i       (benc_upd_v_i),
        .upd_cmd_ack_o      (upd_cmd_ack_o),
        .cmd_upd_rdy_i      (cmd_upd_rdy_i),
        .upd_cmd_ccmd_o     (upd_cmd_ccmd_o),
        .upd_cmd_inst_id_o  (upd_cmd_inst_id_o),
        .upd_cmd_key_o      (upd_cmd_key_o),
        .upd_cmd_v_o        (upd_cmd_v_o),
        .upd_sm_err_o       (upd_sm_err_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- encrypter model controls ----------------
    int           cipher_mode = 0;    // 0: echo plaintext, 1: keyed mixing
    bit           stall_en    = 1'b0; // random rdy stalls and ack delays
    int           ack_limit   = 1000; // ack only while pt_log.size() <= ack_limit
    bit           tag_bad     = 1'b0; // return inst_id 3 instead of the real tag
    int           stray_cnt   = 0;    // bumped by main to request a stray ack
    logic [127:0] pt_log[$];          // plaintexts accepted by the encrypter

    function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] pt);
        if (cipher_mode == 0) return pt;
        return pt ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'h9E3779B9_7F4A7C15_F39CC060_5CEDC834;
    endfunction

    // Reference model: three counter-mode blocks, XOR with provided data, split.
    task automatic model(input logic [2:0] c, input logic [255:0] k, input logic [127:0] v,
                         input logic [383:0] pd, output logic [255:0] ek, output logic [127:0] ev);
        logic [127:0] vv;
        logic [127:0] blk[3];
        logic [383:0] t;
        if (c == CMD_UNI) begin
            ek = '0;
            ev = '0;
        end else begin
            vv = v;
            for (int i = 0; i < 3; i++) begin
                vv     = {vv[127:32], 32'(vv[31:0] + 32'd1)};
                blk[i] = cipher(k, vv);
            end
            t  = {blk[0], blk[1], blk[2]} ^ pd;
            ek = t[383:128];
            ev = t[127:0];
        end
    endtask

    // Bench-side block encrypter: takes a request, answers on the next cycle.
    initial begin : encrypter
        logic [127:0] pend_pt;
        logic [255:0] pend_key;
        logic [2:0]   pend_c;
        logic [3:0]   pend_id;
        logic [127:0] last_pt;
        bit           pend_v;
        bit           stalled;
        int           dly;
        int           stray_done;
        pend_v = 1'b0; stalled = 1'b0; dly = 0; stray_done = 0;
        pend_pt = '0; pend_key = '0; pend_c = '0; pend_id = '0; last_pt = '0;
        benc_upd_rdy_i = 1'b1; benc_upd_ack_i = 1'b0;
        benc_upd_ccmd_i = '0; benc_upd_inst_id_i = '0; benc_upd_v_i = '0;
        forever begin
            @(posedge clk_i); #1;
            benc_upd_ack_i = 1'b0;
            benc_upd_rdy_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (upd_benc_req_o) begin
                if (stalled) check("benc_v_held_while_stalled", upd_benc_v_o, last_pt);
                last_pt = upd_benc_v_o;
                stalled = !benc_upd_rdy_i;
                if (benc_upd_rdy_i) begin
                    pend_pt  = upd_benc_v_o;
                    pend_key = upd_benc_key_o;
                    pend_c   = upd_benc_ccmd_o;
                    pend_id  = upd_benc_inst_id_o;
                    pend_v   = 1'b1;
                    dly      = stall_en ? $urandom_range(0, 2) : 0;
                    pt_log.push_back(upd_benc_v_o);
                end
            end else begin
                stalled = 1'b0;
            end
            if (stray_cnt != stray_done) begin
                stray_done++;
                benc_upd_ack_i     = 1'b1;
                benc_upd_v_i       = '1;
                benc_upd_ccmd_i    = 3'd7;
                benc_upd_inst_id_i = 4'hF;
            end else if (upd_benc_rdy_o && pend_v && pt_log.size() <= ack_limit) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    benc_upd_ack_i     = 1'b1;
                    benc_upd_v_i       = cipher(pend_key, pend_pt);
                    benc_upd_ccmd_i    = pend_c;
                    benc_upd_inst_id_i = tag_bad ? 4'd3 : pend_id;
                    pend_v             = 1'b0;
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- command-side helpers ----------------
    task automatic issue(input logic [2:0] c, input logic [3:0] id, input logic [255:0] k,
                         input logic [127:0] v, input logic [383:0] pd);
        int n = 0;
        while (!upd_cmd_rdy_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!upd_cmd_rdy_o) check("issue_rdy_timeout", upd_cmd_rdy_o, 1);
        cmd_upd_ccmd_i    = c;
        cmd_upd_inst_id_i = id;
        cmd_upd_key_i     = k;
        cmd_upd_v_i       = v;
        cmd_upd_pdata_i   = pd;
        cmd_upd_req_i     = 1'b1;
        @(posedge clk_i); #1;   // acceptance edge = cycle 0
        cmd_upd_req_i     = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 1;
        while (!upd_cmd_ack_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!upd_cmd_ack_o) check("ack_timeout", upd_cmd_ack_o, 1);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    typedef struct {
        logic [2:0]   ccmd;
        logic [3:0]   id;
        logic [255:0] key;
        logic [127:0] v;
        logic [383:0] pdata;
        logic [255:0] exp_key;
        logic [127:0] exp_v;
        int           exp_lat;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t         vecs[4];
        int           lat;
        int           n;
        bit           flag;
        logic [255:0] k;
        logic [127:0] v;
        logic [383:0] pd;
        logic [2:0]   c;
        logic [3:0]   id;
        logic [255:0] ek;
        logic [127:0] ev;

        // Directed vectors, encrypter in echo mode.
        vecs[0] = '{CMD_INS, 4'd2, '0, '0, '0, {128'd1, 128'd2}, 128'd3, 7};
        vecs[1] = '{CMD_RES, 4'd4, '0, {UP, 32'hFFFF_FFFF}, '0,
                    {{UP, 32'd0}, {UP, 32'd1}}, {UP, 32'd2}, 7};
        vecs[2] = '{CMD_UNI, 4'd7, 256'h1234_5678, 128'h55, '1, '0, '0, 1};
        vecs[3] = '{CMD_INS, 4'd9, '0, '0,
                    {128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0,
                     128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F,
                     128'hFF00FF00_FF00FF00_FF00FF00_FF00FF00},
                    {128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F1,
                     128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0D},
                    128'hFF00FF00_FF00FF00_FF00FF00_FF00FF03, 7};

        rst_ni = 1'b0; enable_i = 1'b0; cmd_upd_req_i = 1'b0; cmd_upd_rdy_i = 1'b1;
        cmd_upd_ccmd_i = '0; cmd_upd_inst_id_i = '0; cmd_upd_pdata_i = '0;
        cmd_upd_key_i = '0; cmd_upd_v_i = '0;

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd_rdy",   upd_cmd_rdy_o,  0);
        check("rst_benc_req",  upd_benc_req_o, 0);
        check("rst_benc_rdy",  upd_benc_rdy_o, 0);
        check("rst_cmd_ack",   upd_cmd_ack_o,  0);
        check("rst_sm_err",    upd_sm_err_o,   0);
        check("rst_cmd_key",   upd_cmd_key_o,  0);
        check("rst_benc_v",    upd_benc_v_o,   0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("rdy_enable_low", upd_cmd_rdy_o, 0);
        enable_i = 1'b1;
        #1;
        check("rdy_enable_high", upd_cmd_rdy_o, 1);

        // Table-driven directed vectors.
        cipher_mode = 0;
        for (int i = 0; i < 4; i++) begin
            pt_log.delete();
            issue(vecs[i].ccmd, vecs[i].id, vecs[i].key, vecs[i].v, vecs[i].pdata);
            check($sformatf("v%0d_busy", i), upd_cmd_rdy_o, 0);
            wait_ack(lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_key", i),  upd_cmd_key_o,     vecs[i].exp_key);
            check($sformatf("v%0d_v", i),    upd_cmd_v_o,       vecs[i].exp_v);
            check($sformatf("v%0d_id", i),   upd_cmd_inst_id_o, vecs[i].id);
            check($sformatf("v%0d_ccmd", i), upd_cmd_ccmd_o,    vecs[i].ccmd);
            if (vecs[i].ccmd == CMD_UNI) begin
                check($sformatf("v%0d_no_enc", i), pt_log.size(), 0);
            end else begin
                check($sformatf("v%0d_nblk", i), pt_log.size(), 3);
                if (pt_log.size() == 3) begin
                    for (int b = 0; b < 3; b++)
                        check($sformatf("v%0d_pt%0d", i, b), pt_log[b],
                              {vecs[i].v[127:32], 32'(vecs[i].v[31:0] + 32'(b + 1))});
                end
            end
            @(posedge clk_i); #1;
            check($sformatf("v%0d_ack_drop", i), upd_cmd_ack_o, 0);
            check($sformatf("v%0d_rdy_back", i), upd_cmd_rdy_o, 1);
        end

        // Back-pressure in RESP with a stray ciphertext ack that must be ignored.
        cmd_upd_rdy_i = 1'b0;
        issue(vecs[0].ccmd, vecs[0].id, vecs[0].key, vecs[0].v, vecs[0].pdata);
        wait_ack(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) stray_cnt++;
            @(posedge clk_i); #1;
            check($sformatf("hold%0d_ack", i), upd_cmd_ack_o, 1);
            check($sformatf("hold%0d_key", i), upd_cmd_key_o, vecs[0].exp_key);
            check($sformatf("hold%0d_v", i),   upd_cmd_v_o,   vecs[0].exp_v);
        end
        check("hold_no_err", upd_sm_err_o, 0);
        cmd_upd_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        check("hold_release_ack", upd_cmd_ack_o, 0);
        check("hold_release_rdy", upd_cmd_rdy_o, 1);
        flag = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            flag |= upd_cmd_ack_o;
        end
        check("hold_single_handshake", flag, 0);

        // Disable while waiting for block 1 ciphertext.
        pt_log.delete();
        ack_limit = 1;
        issue(CMD_INS, 4'd6, rand256(), 128'h77, '0);
        n = 0;
        while (!(upd_benc_rdy_o && pt_log.size() == 2) && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("abort_reached_blk1_wait", n < 50, 1);
        enable_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort_benc_rdy", upd_benc_rdy_o, 0);
        check("abort_benc_req", upd_benc_req_o, 0);
        check("abort_cmd_ack",  upd_cmd_ack_o,  0);
        check("abort_benc_v",   upd_benc_v_o,   0);
        check("abort_benc_key", upd_benc_key_o, 0);
        flag = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
            flag |= upd_cmd_ack_o | upd_benc_req_o;
        end
        check("abort_quiet", flag, 0);
        ack_limit = 1000;
        enable_i  = 1'b1;
        #1;
        check("abort_rdy_again", upd_cmd_rdy_o, 1);
        issue(vecs[3].ccmd, vecs[3].id, vecs[3].key, vecs[3].v, vecs[3].pdata);
        wait_ack(lat);
        check("after_abort_key", upd_cmd_key_o, vecs[3].exp_key);
        check("after_abort_v",   upd_cmd_v_o,   vecs[3].exp_v);
        check("after_abort_lat", lat, 7);
        @(posedge clk_i); #1;

        // Randomized commands against the reference model, with stalls.
        cipher_mode = 1;
        stall_en    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            c  = ($urandom_range(0, 3) == 0) ? CMD_UNI : 3'($urandom_range(0, 7));
            id = 4'($urandom());
            k  = rand256();
            v  = rand256()[127:0];
            if (i % 5 == 0) v[31:0] = 32'hFFFF_FFFE;
            pd = {rand256(), rand256()[127:0]};
            model(c, k, v, pd, ek, ev);
            issue(c, id, k, v, pd);
            wait_ack(lat);
            check($sformatf("rnd%0d_key", i),  upd_cmd_key_o,     ek);
            check($sformatf("rnd%0d_v", i),    upd_cmd_v_o,       ev);
            check($sformatf("rnd%0d_id", i),   upd_cmd_inst_id_o, id);
            check($sformatf("rnd%0d_ccmd", i), upd_cmd_ccmd_o,    c);
            @(posedge clk_i); #1;
        end
        stall_en       = 1'b0;
        benc_upd_rdy_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Returned tag mismatch (stored id 2, returned id 3).
        cipher_mode = 0;
        tag_bad     = 1'b1;
        issue(CMD_INS, 4'd2, '0, '0, '0);
`ifdef CSRNG_UPD_TAG_CHECK_EN
        n = 0;
        while (!upd_sm_err_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("tag_err_set", upd_sm_err_o, 1);
        check("tag_err_rdy", upd_cmd_rdy_o, 0);
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        enable_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("tag_err_sticky",  upd_sm_err_o,   1);
        check("tag_err_no_rdy",  upd_cmd_rdy_o,  0);
        check("tag_err_no_ack",  upd_cmd_ack_o,  0);
        check("tag_err_no_req",  upd_benc_req_o, 0);
`else
        wait_ack(lat);
        check("tag_ignored_key", upd_cmd_key_o, {128'd1, 128'd2});
        check("tag_ignored_v",   upd_cmd_v_o,   128'd3);
        check("tag_ignored_err", upd_sm_err_o,  0);
        @(posedge clk_i); #1;
`endif
        tag_bad  = 1'b0;
        enable_i = 1'b0;
        rst_ni   = 1'b0;
        #1;
        check("final_rst_err", upd_sm_err_o,  0);
        check("final_rst_ack", upd_cmd_ack_o, 0);
        check("final_rst_rdy", upd_cmd_rdy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
